hpc1_rnd_feeder: RTL

HPC1_RND_FEEDER -- requirements
Module: hpc1_rnd_feeder

---
 rtl/hpc1_rnd_feeder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/hpc1_rnd_feeder.sv
// rtl/hpc1_rnd_feeder.sv - LFSR-based randomness feeder for an HPC1 masked gadget.
// Seeds a 64-bit LFSR from bytes, discards a warm-up run, then streams RND_W fresh bits per word.
module hpc1_rnd_feeder #(
  parameter int security_order = 2,
  parameter int WARMUP         = 64,
  localparam int D             = security_order + 1,
  localparam int RND_W         = D * (D - 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_valid,
  input  logic [7:0]       seed_data,
  output logic             seed_ready,
  input  logic             reseed,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [RND_W-1:0] rnd
);

  typedef enum logic [1:0] {
    ST_SEED = 2'd0,
    ST_WARM = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [63:0]        s_q, s_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         warm_cnt_q, warm_cnt_d;
  logic [RND_W-1:0]   rnd_q, rnd_d;
  logic               rnd_valid_q, rnd_valid_d;

  logic [63:0]        seed_shift;
  logic [RND_W+63:0]  adv1;
  logic [RND_W+63:0]  adv2;

  // Returns {emitted_bits, next_state}; bit i of emitted_bits comes from step i.
  function automatic logic [RND_W+63:0] advance(input logic [63:0] s_in);
    logic [63:0]      s;
    logic [RND_W-1:0] b;
    logic             fb;
    s = s_in;
    b = '0;
    for (int i = 0; i < RND_W; i++) begin
      fb   = s[63] ^ s[62] ^ s[60] ^ s[59];
      s    = {s[62:0], fb};
      b[i] = fb;
    end
    return {b, s};
  endfunction

  // The last warm-up edge discards one advance and presents the following one.
  assign adv1       = advance(s_q);
  assign adv2       = advance(adv1[63:0]);
  assign seed_shift = {s_q[55:0], seed_data};

  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    byte_cnt_d  = byte_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    rnd_d       = rnd_q;
    rnd_valid_d = rnd_valid_q;
    case (state_q)
      ST_SEED: begin
        if (reseed) begin
          byte_cnt_d = 3'd0;
        end else if (seed_valid) begin
          s_d        = seed_shift;
          byte_cnt_d = byte_cnt_q + 3'd1;
          if (byte_cnt_q == 3'd7) begin
            state_d    = ST_WARM;
            warm_cnt_d = 8'd0;
            if (seed_shift == 64'h0) begin
              s_d = 64'h1;
            end
          end
        end
      end
      ST_WARM: begin
        if (reseed) begin
          state_d     = ST_SEED;
          byte_cnt_d  = 3'd0;
          rnd_valid_d = 1'b0;
        end else if (warm_cnt_q == 8'(WARMUP - 1)) begin
          s_d         = adv2[63:0];
          rnd_d       = adv2[RND_W+63:64];
          rnd_valid_d = 1'b1;
          warm_cnt_d  = warm_cnt_q + 8'd1;
          state_d     = ST_RUN;
        end else begin
          s_d        = adv1[63:0];
          warm_cnt_d = warm_cnt_q + 8'd1;
        end
      end
      ST_RUN: begin
        if (reseed) begin
          state_d     = ST_SEED;
          byte_cnt_d  = 3'd0;
          rnd_valid_d = 1'b0;
        end else if (rnd_ready) begin
          s_d   = adv1[63:0];
          rnd_d = adv1[RND_W+63:64];
        end
      end
      default: begin
        state_d     = ST_SEED;
        byte_cnt_d  = 3'd0;
        rnd_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEED;
      s_q         <= 64'h0;
      byte_cnt_q  <= 3'd0;
      warm_cnt_q  <= 8'd0;
      rnd_q       <= '0;
      rnd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      byte_cnt_q  <= byte_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
    end
  end

  assign seed_ready = (state_q == ST_SEED);
  assign rnd_valid  = rnd_valid_q;
  assign rnd        = rnd_q;

endmodule
